chipram_sdram_arb: RTL and testbench



---
 rtl/chipram_sdram_arb.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_chipram_sdram_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chipram_sdram_arb.sv
// Chip RAM SDRAM controller and arbiter.
// Runs the SDRAM power-up sequence, then shares the device between Agnus
// DMA and the 68040. Refresh has top priority and DMA has priority over the
// CPU. A starvation guard hands the CPU every third access while both
// requesters are active.
// Each access is a single word with auto-precharge. Every output comes from
// a register, so a command decided at a clock edge appears on the pins
// during the following cycle.
module chipram_sdram_arb #(
  parameter int INIT_CYCLES  = 16000,
  parameter int REF_INTERVAL = 624,
  parameter int TRCD         = 2,
  parameter int CL           = 2,
  parameter int TRP          = 2,
  parameter int TWR          = 2,
  parameter int TRFC         = 6
) (
  input  logic       CLK80,
  input  logic       RESET,
  input  logic       DMA_REQ,
  input  logic       DMA_RnW,
  input  logic       CPU_REQ,
  input  logic       CPU_RnW,
  output logic       GNT_DMA,
  output logic       GNT_CPU,
  output logic       ACK,
  output logic       nSDRAM_CS,
  output logic       nRAS,
  output logic       nCAS,
  output logic       nWE,
  output logic       CLKE,
  output logic [1:0] MA_SEL,
  output logic       INIT_DONE
);

  // One counter times every state. It must be wide enough for the longest
  // wait, which is the power-up NOP period.
  localparam int CntW = $clog2(INIT_CYCLES + TRCD + CL + TRP + TWR + TRFC + 4);
  localparam int RefW = $clog2(REF_INTERVAL + 1);

  localparam logic [CntW-1:0] InitLast  = CntW'(INIT_CYCLES);
  localparam logic [CntW-1:0] TrpLast   = CntW'(TRP - 1);
  localparam logic [CntW-1:0] TrfcLast  = CntW'(TRFC - 1);
  localparam logic [CntW-1:0] MrsLast   = CntW'(1);
  localparam logic [CntW-1:0] TrcdLast  = CntW'(TRCD - 1);
  localparam logic [CntW-1:0] ClLast    = CntW'(CL - 1);
  localparam logic [CntW-1:0] WrRecLast = CntW'(TWR + TRP - 1);
  localparam logic [RefW-1:0] RefLast   = RefW'(REF_INTERVAL - 1);

  // Command encodings are {CS, RAS, CAS, WE}, all active low.
  localparam logic [3:0] CmdInh   = 4'b1111;
  localparam logic [3:0] CmdNop   = 4'b0111;
  localparam logic [3:0] CmdAct   = 4'b0011;
  localparam logic [3:0] CmdRead  = 4'b0101;
  localparam logic [3:0] CmdWrite = 4'b0100;
  localparam logic [3:0] CmdPre   = 4'b0010;
  localparam logic [3:0] CmdRef   = 4'b0001;
  localparam logic [3:0] CmdMrs   = 4'b0000;

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS,
    IDLE, ACT, RW, RD_WAIT, RECOVER, REFRESH
  } state_t;

  state_t          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  logic [RefW-1:0] refCnt;
  logic            refPending, refWrap, refDue, refIssue;
  logic            ownerDma, ownerDmaNext;
  logic            rnw, rnwNext;
  logic [1:0]      streak, streakNext;
  logic            goArb, dmaWins, accessNext;

  logic [3:0]      cmdReg, cmdNext;
  logic [1:0]      maSelReg, maSelNext;
  logic            clkeReg;
  logic            gntDmaReg, gntDmaNext;
  logic            gntCpuReg, gntCpuNext;
  logic            ackReg, ackNext;
  logic            initDoneReg, initDoneNext;

  // A refresh is due in the cycle the interval counter expires, so an
  // arbitration at that edge already sees it, and afterwards until served.
  assign refWrap = (refCnt == RefLast);
  assign refDue  = refPending || refWrap;

  // After two DMA grants in a row that made a waiting CPU step aside, the
  // CPU wins the next non-refresh arbitration.
  assign dmaWins = DMA_REQ && !((streak == 2'd2) && CPU_REQ);

  // Free-running refresh interval timer with a one-deep pending flag.
  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      refCnt     <= '0;
      refPending <= 1'b0;
    end else begin
      refCnt <= refWrap ? '0 : refCnt + 1'b1;
      if (refIssue) begin
        refPending <= 1'b0;
      end else if (refWrap) begin
        refPending <= 1'b1;
      end
    end
  end

  // FSM state, cycle counter and the attributes latched at grant time.
  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      state    <= INIT_WAIT;
      cnt      <= '0;
      ownerDma <= 1'b0;
      rnw      <= 1'b0;
      streak   <= 2'd0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      ownerDma <= ownerDmaNext;
      rnw      <= rnwNext;
      streak   <= streakNext;
    end
  end

  // Next state and next pin values. The command shows only on the cycle a
  // state is entered and NOP is sent while a state waits. The end of
  // recovery and the end of refresh arbitrate immediately, so back-to-back
  // work loses no cycle in IDLE.
  always_comb begin
    stateNext    = state;
    cntNext      = cnt + 1'b1;
    cmdNext      = CmdNop;
    maSelNext    = 2'b00;
    ownerDmaNext = ownerDma;
    rnwNext      = rnw;
    streakNext   = streak;
    refIssue     = 1'b0;
    goArb        = 1'b0;

    case (state)
      INIT_WAIT: begin
        if (cnt == InitLast) begin
          stateNext = INIT_PRE;
          cntNext   = '0;
          cmdNext   = CmdPre;
          maSelNext = 2'b10;
        end
      end
      INIT_PRE: begin
        if (cnt == TrpLast) begin
          stateNext = INIT_REF1;
          cntNext   = '0;
          cmdNext   = CmdRef;
          refIssue  = 1'b1;
        end
      end
      INIT_REF1: begin
        if (cnt == TrfcLast) begin
          stateNext = INIT_REF2;
          cntNext   = '0;
          cmdNext   = CmdRef;
          refIssue  = 1'b1;
        end
      end
      INIT_REF2: begin
        if (cnt == TrfcLast) begin
          stateNext = INIT_MRS;
          cntNext   = '0;
          cmdNext   = CmdMrs;
          maSelNext = 2'b11;
        end
      end
      INIT_MRS: begin
        // Leave unconditionally: requests seen while INIT_DONE was low are
        // not acted on until IDLE has been shown for one cycle.
        if (cnt == MrsLast) begin
          stateNext = IDLE;
          cntNext   = '0;
        end
      end
      IDLE: begin
        goArb = 1'b1;
      end
      ACT: begin
        if (cnt == TrcdLast) begin
          stateNext = RW;
          cntNext   = '0;
          cmdNext   = rnw ? CmdRead : CmdWrite;
          maSelNext = 2'b01;
        end
      end
      RW: begin
        stateNext = rnw ? RD_WAIT : RECOVER;
        cntNext   = '0;
      end
      RD_WAIT: begin
        if (cnt == ClLast) begin
          stateNext = RECOVER;
          cntNext   = '0;
        end
      end
      RECOVER: begin
        if (rnw ? (cnt == TrpLast) : (cnt == WrRecLast)) begin
          goArb = 1'b1;
        end
      end
      REFRESH: begin
        if (cnt == TrfcLast) begin
          goArb = 1'b1;
        end
      end
      default: begin
        stateNext = INIT_WAIT;
        cntNext   = '0;
      end
    endcase

    if (goArb) begin
      stateNext = IDLE;
      cntNext   = '0;
      if (refDue) begin
        stateNext = REFRESH;
        cmdNext   = CmdRef;
        refIssue  = 1'b1;
      end else if (dmaWins) begin
        stateNext    = ACT;
        cmdNext      = CmdAct;
        ownerDmaNext = 1'b1;
        rnwNext      = DMA_RnW;
        if (!CPU_REQ) begin
          streakNext = 2'd0;
        end else if (streak != 2'd2) begin
          streakNext = streak + 2'd1;
        end
      end else if (CPU_REQ) begin
        stateNext    = ACT;
        cmdNext      = CmdAct;
        ownerDmaNext = 1'b0;
        rnwNext      = CPU_RnW;
        streakNext   = 2'd0;
      end
    end

    // A write is acknowledged with its command. A read is acknowledged on
    // the last CAS-latency cycle, when the data is on the bus.
    accessNext   = stateNext inside {ACT, RW, RD_WAIT, RECOVER};
    gntDmaNext   = accessNext && ownerDmaNext;
    gntCpuNext   = accessNext && !ownerDmaNext;
    ackNext      = ((stateNext == RW) && !rnwNext) ||
                   ((stateNext == RD_WAIT) && (cntNext == ClLast));
    initDoneNext = !(stateNext inside {INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_MRS});
  end

  // Output registers. Reset drives the command lines inactive and drops
  // CKE. CKE is raised on the first clock after reset is released.
  always_ff @(posedge CLK80 or posedge RESET) begin
    if (RESET) begin
      cmdReg      <= CmdInh;
      maSelReg    <= 2'b00;
      clkeReg     <= 1'b0;
      gntDmaReg   <= 1'b0;
      gntCpuReg   <= 1'b0;
      ackReg      <= 1'b0;
      initDoneReg <= 1'b0;
    end else begin
      cmdReg      <= cmdNext;
      maSelReg    <= maSelNext;
      clkeReg     <= 1'b1;
      gntDmaReg   <= gntDmaNext;
      gntCpuReg   <= gntCpuNext;
      ackReg      <= ackNext;
      initDoneReg <= initDoneNext;
    end
  end

  assign {nSDRAM_CS, nRAS, nCAS, nWE} = cmdReg;
  assign MA_SEL    = maSelReg;
  assign CLKE      = clkeReg;
  assign GNT_DMA   = gntDmaReg;
  assign GNT_CPU   = gntCpuReg;
  assign ACK       = ackReg;
  assign INIT_DONE = initDoneReg;

endmodule

// File: tb/tb_chipram_sdram_arb.sv
// Bench for chipram_sdram_arb with INIT_CYCLES=8 and REF_INTERVAL=64.
// A cycle table covers power-up, single accesses and refresh priority.
// Hand-written sequences cover continuous contention and reset mid-read.
module tb_chipram_sdram_arb;

  localparam logic [3:0] C_INH = 4'b1111;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       dmaReq, dmaRnw, cpuReq, cpuRnw;
  logic       gntDma, gntCpu, ack, nCs, nRas, nCas, nWe, clke, initDone;
  logic [1:0] maSel;

  int nChecks = 0;
  int nFails  = 0;
  int cyc;
  int ackCount = 0;

  typedef struct {
    int          reps;
    logic [3:0]  stim;   // {DMA_REQ, DMA_RnW, CPU_REQ, CPU_RnW}
    logic [10:0] exp;    // {GNT_DMA, GNT_CPU, ACK, CS, RAS, CAS, WE, CLKE, MA_SEL, INIT_DONE}
    string       name;
  } vec_t;

  vec_t vecs[$];

  chipram_sdram_arb #(.INIT_CYCLES(8), .REF_INTERVAL(64)) dut (
    .CLK80    (clk),
    .RESET    (rst),
    .DMA_REQ  (dmaReq),
    .DMA_RnW  (dmaRnw),
    .CPU_REQ  (cpuReq),
    .CPU_RnW  (cpuRnw),
    .GNT_DMA  (gntDma),
    .GNT_CPU  (gntCpu),
    .ACK      (ack),
    .nSDRAM_CS(nCs),
    .nRAS     (nRas),
    .nCAS     (nCas),
    .nWE      (nWe),
    .CLKE     (clke),
    .MA_SEL   (maSel),
    .INIT_DONE(initDone)
  );

  always #5 clk = ~clk;

  // Edge number since reset release. Edge 1 is the first rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (ack === 1'b1) ackCount++;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [10:0] mk(input logic gd, input logic gc, input logic ak,
                                     input logic [3:0] cmd, input logic ck,
                                     input logic [1:0] ma, input logic idn);
    return {gd, gc, ak, cmd, ck, ma, idn};
  endfunction

  function automatic logic [10:0] outs();
    return {gntDma, gntCpu, ack, nCs, nRas, nCas, nWe, clke, maSel, initDone};
  endfunction

  function automatic logic [3:0] cmdNow();
    return {nCs, nRas, nCas, nWe};
  endfunction

  function automatic void add(input int reps, input logic [3:0] stim,
                              input logic [10:0] exp, input string name);
    vec_t v;
    v.reps = reps;
    v.stim = stim;
    v.exp  = exp;
    v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s (edge %0d): got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [10:0] rstVals;
    int nGr, nRef, overlap, ackBefore;
    bit found;

    rstVals = mk(0, 0, 0, C_INH, 0, 2'b00, 0);
    rst = 1'b1;
    dmaReq = 1'b0; dmaRnw = 1'b0; cpuReq = 1'b0; cpuRnw = 1'b0;

    // Power-up. The CPU request is held throughout and must be ignored.
    add(8,  4'b0011, mk(0,0,0,C_NOP,1,2'b00,0), "init nop, cpu ignored");
    add(1,  4'b0011, mk(0,0,0,C_PRE,1,2'b10,0), "init precharge-all");
    add(1,  4'b0011, mk(0,0,0,C_NOP,1,2'b00,0), "init trp");
    add(1,  4'b0011, mk(0,0,0,C_REF,1,2'b00,0), "init ref1");
    add(5,  4'b0011, mk(0,0,0,C_NOP,1,2'b00,0), "init trfc1");
    add(1,  4'b0011, mk(0,0,0,C_REF,1,2'b00,0), "init ref2");
    add(5,  4'b0011, mk(0,0,0,C_NOP,1,2'b00,0), "init trfc2");
    add(1,  4'b0011, mk(0,0,0,C_MRS,1,2'b11,0), "init mrs");
    add(1,  4'b0011, mk(0,0,0,C_NOP,1,2'b00,0), "init mrs wait");
    add(1,  4'b0011, mk(0,0,0,C_NOP,1,2'b00,1), "init done idle");
    // CPU read: ACT t=26, READ t+2, ACK t+4, grant through t+6.
    add(1,  4'b0011, mk(0,1,0,C_ACT,1,2'b00,1), "cpu read act");
    add(1,  4'b0011, mk(0,1,0,C_NOP,1,2'b00,1), "cpu read trcd");
    add(1,  4'b0011, mk(0,1,0,C_RD, 1,2'b01,1), "cpu read cmd");
    add(1,  4'b0011, mk(0,1,0,C_NOP,1,2'b00,1), "cpu read cl");
    add(1,  4'b0011, mk(0,1,1,C_NOP,1,2'b00,1), "cpu read ack");
    add(2,  4'b0000, mk(0,1,0,C_NOP,1,2'b00,1), "cpu read recover");
    add(1,  4'b0000, mk(0,0,0,C_NOP,1,2'b00,1), "cpu read idle");
    // DMA write and CPU write together: DMA first (t=34), CPU ACT at t+7.
    add(1,  4'b1010, mk(1,0,0,C_ACT,1,2'b00,1), "dma wins act");
    add(1,  4'b1010, mk(1,0,0,C_NOP,1,2'b00,1), "dma write trcd");
    add(1,  4'b1010, mk(1,0,1,C_WR, 1,2'b01,1), "dma write ack");
    add(4,  4'b0010, mk(1,0,0,C_NOP,1,2'b00,1), "dma write recover");
    add(1,  4'b0010, mk(0,1,0,C_ACT,1,2'b00,1), "cpu act after dma");
    add(1,  4'b0010, mk(0,1,0,C_NOP,1,2'b00,1), "cpu write trcd");
    add(1,  4'b0010, mk(0,1,1,C_WR, 1,2'b01,1), "cpu write ack");
    add(4,  4'b0000, mk(0,1,0,C_NOP,1,2'b00,1), "cpu write recover");
    add(16, 4'b0000, mk(0,0,0,C_NOP,1,2'b00,1), "idle before refresh");
    // The refresh interval expires together with a DMA read request.
    add(1,  4'b1100, mk(0,0,0,C_REF,1,2'b00,1), "refresh beats dma");
    add(5,  4'b1100, mk(0,0,0,C_NOP,1,2'b00,1), "refresh trfc");
    add(1,  4'b1100, mk(1,0,0,C_ACT,1,2'b00,1), "dma act after refresh");
    add(1,  4'b1100, mk(1,0,0,C_NOP,1,2'b00,1), "dma read trcd");
    add(1,  4'b1100, mk(1,0,0,C_RD, 1,2'b01,1), "dma read cmd");
    add(1,  4'b1100, mk(1,0,0,C_NOP,1,2'b00,1), "dma read cl");
    add(1,  4'b1100, mk(1,0,1,C_NOP,1,2'b00,1), "dma read ack");
    add(2,  4'b0000, mk(1,0,0,C_NOP,1,2'b00,1), "dma read recover");
    add(1,  4'b0000, mk(0,0,0,C_NOP,1,2'b00,1), "dma read idle");

    @(negedge clk);
    check("reset values", outs(), rstVals);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        {dmaReq, dmaRnw, cpuReq, cpuRnw} = vecs[i].stim;
        tick();
        check(vecs[i].name, outs(), vecs[i].exp);
      end
    end

    // Continuous contention. Grants must go D, D, C repeatedly. Each refresh
    // must land within one access of the interval expiring.
    dmaReq = 1'b1; dmaRnw = 1'b1; cpuReq = 1'b1; cpuRnw = 1'b0;
    nGr = 0; nRef = 0; overlap = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (gntDma && gntCpu) overlap++;
      if (cmdNow() == C_ACT) begin
        checkInt($sformatf("grant %0d is cpu", nGr), int'(gntCpu), (nGr % 3 == 2) ? 1 : 0);
        nGr++;
      end
      if (cmdNow() == C_REF) begin
        checkInt("refresh lateness ok", int'((cyc % 64) <= 7), 1);
        checkInt("refresh without grant", int'(gntDma || gntCpu), 0);
        nRef++;
      end
    end
    checkInt("grants in contention run", int'(nGr >= 12), 1);
    checkInt("refreshes in contention run", nRef, 1);
    checkInt("grant overlap cycles", overlap, 0);
    dmaReq = 1'b0; cpuReq = 1'b0;
    repeat (10) tick();

    // Reset asserted in the middle of a read, while waiting on CAS latency.
    cpuReq = 1'b1; cpuRnw = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (cmdNow() == C_ACT) found = 1'b1;
    end
    checkInt("cpu act before reset", int'(found), 1);
    ackBefore = ackCount;
    repeat (3) tick();
    check("in rd_wait before reset", outs(), mk(0,1,0,C_NOP,1,2'b00,1));
    #2 rst = 1'b1;
    #1 check("async reset mid-read", outs(), rstVals);
    cpuReq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset held", outs(), rstVals);
    rst = 1'b0;
    tick();
    check("first clock after reset", outs(), mk(0,0,0,C_NOP,1,2'b00,0));
    checkInt("no ack after mid-read reset", ackCount, ackBefore);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (cmdNow() == C_PRE) found = 1'b1;
    end
    checkInt("reinit precharge seen", int'(found), 1);
    checkInt("reinit precharge edge", cyc, 9);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (initDone) found = 1'b1;
    end
    checkInt("reinit done seen", int'(found), 1);
    checkInt("reinit done edge", cyc, 25);
    check("reinit idle state", outs(), mk(0,0,0,C_NOP,1,2'b00,1));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
